// File: rtl/fsm_stream_pkg.sv
// Shared types for the stream-wrapped 4-state FSM.
// State encoding and result-message layout are used by the top and the next-state logic.
package fsm_stream_pkg;

    localparam int unsigned STATE_W   = 2;
    localparam int unsigned MOORE_W   = 1;
    localparam int unsigned OUT_MSG_W = STATE_W + MOORE_W;
    localparam int unsigned IN_MSG_W  = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_A = 2'd0,
        ST_B = 2'd1,
        ST_C = 2'd2,
        ST_D = 2'd3
    } state_e;

    // Result message: {next_state, moore_out}
    typedef struct packed {
        state_e             next_state;
        logic [MOORE_W-1:0] moore;
    } out_msg_t;

endpackage

// File: rtl/fsm_4s2i1o_next_logic.sv
// Combinational next-state table and Moore output of the 4-state, 2-bit-input FSM.
// 'out' is the Moore output of the state being entered (state_next).
module fsm_4s2i1o_next_logic
    import fsm_stream_pkg::*;
(
    input  state_e              state,
    input  logic [IN_MSG_W-1:0] in_,
    output state_e              state_next,
    output logic                out
);

    // Next-state table; symbols 10 and 11 always lead to A and D respectively
    always_comb begin
        state_next = state;
        unique case (in_)
            2'b00: begin
                unique case (state)
                    ST_A:    state_next = ST_A;
                    ST_B:    state_next = ST_C;
                    ST_C:    state_next = ST_A;
                    default: state_next = ST_C;
                endcase
            end
            2'b01: begin
                unique case (state)
                    ST_A:    state_next = ST_B;
                    ST_B:    state_next = ST_B;
                    ST_C:    state_next = ST_D;
                    default: state_next = ST_B;
                endcase
            end
            2'b10:   state_next = ST_A;
            default: state_next = ST_D;
        endcase
    end

    // Moore output: high only in D
    always_comb begin
        out = (state_next == ST_D);
    end

endmodule

// File: rtl/fsm_stream_ctrl.sv
// Valid/ready stream wrapper around the 4-state FSM with a single-entry result buffer.
// Optional D-entry hit counter enabled by defining FSM_STREAM_CTRL_HITCNT_EN.
module fsm_stream_ctrl
    import fsm_stream_pkg::*;
#(
    parameter int unsigned HIT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 restart,
    input  logic                 in_val,
    output logic                 in_rdy,
    input  logic [IN_MSG_W-1:0]  in_msg,
    output logic                 out_val,
    input  logic                 out_rdy,
    output logic [OUT_MSG_W-1:0] out_msg,
    output logic [STATE_W-1:0]   state,
    input  logic                 hit_clr,
    output logic [HIT_W-1:0]     hit_count
);

    state_e   state_q, state_d;
    logic     out_val_q, out_val_d;
    out_msg_t out_msg_q, out_msg_d;
    state_e   nl_state;
    logic     nl_moore;
    logic     xfer;

    fsm_4s2i1o_next_logic u_next_logic (
        .state      (state_q),
        .in_        (in_msg),
        .state_next (nl_state),
        .out        (nl_moore)
    );

    // State register and single-entry output buffer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_A;
            out_val_q <= 1'b0;
            out_msg_q <= '0;
        end else begin
            state_q   <= state_d;
            out_val_q <= out_val_d;
            out_msg_q <= out_msg_d;
        end
    end

    // Next state: restart wins, then transfer (may replace a popped entry), then pop
    always_comb begin
        state_d   = state_q;
        out_val_d = out_val_q;
        out_msg_d = out_msg_q;
        if (restart) begin
            state_d   = ST_A;
            out_val_d = 1'b0;
        end else if (xfer) begin
            state_d              = nl_state;
            out_val_d            = 1'b1;
            out_msg_d.next_state = nl_state;
            out_msg_d.moore      = nl_moore;
        end else if (out_val_q && out_rdy) begin
            out_val_d = 1'b0;
        end
    end

    // Outputs: handshake ready and registered buffer/state
    always_comb begin
        in_rdy  = !restart && (!out_val_q || out_rdy);
        xfer    = in_val && in_rdy;
        out_val = out_val_q;
        out_msg = OUT_MSG_W'(out_msg_q);
        state   = STATE_W'(state_q);
    end

`ifdef FSM_STREAM_CTRL_HITCNT_EN
    logic [HIT_W-1:0] hit_q, hit_d;

    // Hit counter register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit_q <= '0;
        end else begin
            hit_q <= hit_d;
        end
    end

    // Saturating count of transfers entering D; clear has priority
    always_comb begin
        hit_d = hit_q;
        if (hit_clr) begin
            hit_d = '0;
        end else if (xfer && !restart && (nl_state == ST_D) && (hit_q != {HIT_W{1'b1}})) begin
            hit_d = hit_q + HIT_W'(1);
        end
    end

    assign hit_count = hit_q;
`else
    logic unused_hit_clr;

    // Counter feature absent: constant zero output
    assign unused_hit_clr = hit_clr;
    assign hit_count      = '0;
`endif

endmodule

// File: tb/tb_fsm_stream_ctrl.sv
// Self-checking bench for fsm_stream_ctrl: directed scenarios plus randomized traffic
// against a transaction-level reference model. Honors FSM_STREAM_CTRL_HITCNT_EN.
module tb_fsm_stream_ctrl;

    localparam int unsigned HIT_W   = 8;
    localparam int unsigned HIT_MAX = (1 << HIT_W) - 1;
`ifdef FSM_STREAM_CTRL_HITCNT_EN
    localparam bit HIT_EN = 1'b1;
`else
    localparam bit HIT_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             restart;
    logic             in_val;
    logic             in_rdy;
    logic [1:0]       in_msg;
    logic             out_val;
    logic             out_rdy;
    logic [2:0]       out_msg;
    logic [1:0]       state;
    logic             hit_clr;
    logic [HIT_W-1:0] hit_count;

    fsm_stream_ctrl #(.HIT_W(HIT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .restart   (restart),
        .in_val    (in_val),
        .in_rdy    (in_rdy),
        .in_msg    (in_msg),
        .out_val   (out_val),
        .out_rdy   (out_rdy),
        .out_msg   (out_msg),
        .state     (state),
        .hit_clr   (hit_clr),
        .hit_count (hit_count)
    );

    always #5 clk = ~clk;

    // Transition table rows per state A..D, columns per symbol 00..11
    int unsigned nxt_tbl [4][4] = '{'{0, 1, 0, 3}, '{2, 1, 0, 3}, '{0, 3, 0, 3}, '{2, 1, 0, 3}};

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    int unsigned m_st;
    bit          m_ov;
    int unsigned m_msg;
    int unsigned m_hit;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        m_st  = 0;
        m_ov  = 1'b0;
        m_msg = 0;
        m_hit = 0;
    endtask

    task automatic check_outs();
        check("state", 32'(state), m_st);
        check("out_val", 32'(out_val), 32'(m_ov));
        if (m_ov) check("out_msg", 32'(out_msg), m_msg);
        check("hit_count", 32'(hit_count), m_hit);
    endtask

    // One cycle: drive at negedge, check ready, advance model at posedge, check results
    task automatic step(input bit iv, input bit [1:0] im, input bit ordy, input bit rs, input bit hc);
        bit          exp_rdy;
        bit          xf;
        int unsigned ns;
        @(negedge clk);
        in_val  = iv;
        in_msg  = im;
        out_rdy = ordy;
        restart = rs;
        hit_clr = hc;
        #1;
        exp_rdy = !rs && (!m_ov || ordy);
        check("in_rdy", 32'(in_rdy), 32'(exp_rdy));
        @(posedge clk);
        xf = iv && exp_rdy;
        if (rs) begin
            m_st = 0;
            m_ov = 1'b0;
        end else if (xf) begin
            ns    = nxt_tbl[m_st][im];
            m_st  = ns;
            m_ov  = 1'b1;
            m_msg = ns * 2 + ((ns == 3) ? 1 : 0);
            if (HIT_EN && ns == 3 && m_hit < HIT_MAX) m_hit++;
        end else if (m_ov && ordy) begin
            m_ov = 1'b0;
        end
        if (HIT_EN && hc) m_hit = 0;
        #1;
        check_outs();
    endtask

    // Asynchronous reset in the middle of a cycle; outputs must clear without a clock edge
    task automatic async_reset();
        @(negedge clk);
        in_val  = 1'b0;
        restart = 1'b0;
        hit_clr = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check("rst_state", 32'(state), 0);
        check("rst_out_val", 32'(out_val), 0);
        check("rst_out_msg", 32'(out_msg), 0);
        check("rst_hit", 32'(hit_count), 0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int unsigned hit_before;
        reset   = 1'b1;
        restart = 1'b0;
        in_val  = 1'b0;
        in_msg  = 2'b00;
        out_rdy = 1'b1;
        hit_clr = 1'b0;
        model_reset();

        // Reset with no clock edge yet
        #1;
        check("por_state", 32'(state), 0);
        check("por_out_val", 32'(out_val), 0);
        check("por_hit", 32'(hit_count), 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Basic sequence: 01, 00, 01 from A
        step(1'b1, 2'b01, 1'b1, 1'b0, 1'b0);
        check("seq_msg0", 32'(out_msg), 32'b010);
        step(1'b1, 2'b00, 1'b1, 1'b0, 1'b0);
        check("seq_msg1", 32'(out_msg), 32'b100);
        step(1'b1, 2'b01, 1'b1, 1'b0, 1'b0);
        check("seq_msg2", 32'(out_msg), 32'b111);
        check("seq_state", 32'(state), 3);
        check("seq_hit", 32'(hit_count), HIT_EN ? 1 : 0);

        // Back-pressure: drain, then 4 cycles of in_val with out_rdy low
        step(1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
        check("bp_state", 32'(state), 1);
        check("bp_msg", 32'(out_msg), 32'b010);
        check("bp_rdy", 32'(in_rdy), 0);
        step(1'b1, 2'b00, 1'b1, 1'b0, 1'b0);
        check("bp_pop_state", 32'(state), 2);
        check("bp_pop_val", 32'(out_val), 1);
        check("bp_pop_msg", 32'(out_msg), 32'b100);

        // Restart in C with a would-be transfer
        hit_before = 32'(hit_count);
        step(1'b1, 2'b01, 1'b1, 1'b1, 1'b0);
        check("rs_state", 32'(state), 0);
        check("rs_out_val", 32'(out_val), 0);
        check("rs_hit", 32'(hit_count), hit_before);

        // Saturation and clear
        async_reset();
        for (int i = 0; i < 300; i++) step(1'b1, 2'b11, 1'b1, 1'b0, 1'b0);
        check("sat_hit", 32'(hit_count), HIT_EN ? 255 : 0);
        step(1'b1, 2'b11, 1'b1, 1'b0, 1'b1);
        check("clr_hit", 32'(hit_count), 0);

        // Randomized traffic with occasional restart, clear and async reset
        for (int i = 0; i < 1500; i++) begin
            if (i % 400 == 399) async_reset();
            step(($urandom % 4) != 0, 2'($urandom % 4), ($urandom % 3) != 0,
                 ($urandom % 20) == 0, ($urandom % 50) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fsm_stream_ctrl.md
FSM_STREAM_CTRL -- requirements
Module: fsm_stream_ctrl

Interface
REQ-001 SHALL have parameter HIT_W, default 8, giving the width of the D-state hit counter.
REQ-002 SHALL have clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have reset, input, 1, an asynchronous, active-high reset.
REQ-004 SHALL have restart, input, 1, a synchronous return of the FSM to state A.
REQ-005 SHALL have in_val, input, 1, and in_rdy, output, 1, forming the input-symbol handshake.
REQ-006 SHALL have in_msg, input, 2, the input symbol in_.
REQ-007 SHALL have out_val, output, 1, and out_rdy, input, 1, forming the result handshake.
REQ-008 SHALL have out_msg, output, 3, carrying {next_state[1:0], moore_out}.
REQ-009 SHALL have state, output, 2, the current registered FSM state.
REQ-010 SHALL have hit_clr, input, 1, a synchronous clear of the hit counter.
REQ-011 SHALL have hit_count, output, HIT_W, the hit counter value.

Function
REQ-012 SHALL encode the states as A=0, B=1, C=2, D=3.
REQ-013 SHALL use this next-state table, listed per state for in_=00/01/10/11:
- A: A/B/A/D
- B: C/B/A/D
- C: A/D/A/D
- D: C/B/A/D
REQ-014 SHALL produce the Moore output 1 only in state D and 0 in states A, B and C.
REQ-015 SHALL define a transfer as in_val && in_rdy at a rising edge.
REQ-016 SHALL make in_rdy = !restart && (!out_val || out_rdy); the output buffer is a single entry.
REQ-017 SHALL, on a transfer at edge t, register state <= next_state(state, in_msg) at edge t.
REQ-018 SHALL, on that same transfer, load out_msg = {next_state, moore_out(next_state)} and set out_val = 1 from cycle t+1; latency is 1 cycle.
REQ-019 SHALL clear out_val on an edge with out_val && out_rdy and no new transfer.
REQ-020 SHALL replace the output entry without a bubble when a pop and a transfer occur on the same edge.
REQ-021 SHALL hold state and out_msg unchanged while out_val && !out_rdy; no symbol is lost or duplicated.
REQ-022 SHALL increment hit_count by 1 on every transfer whose next_state is D, including D->D self-loops.
REQ-023 SHALL saturate hit_count at 2^HIT_W-1; it does not wrap.
REQ-024 SHALL give hit_clr priority over a same-edge increment; hit_count becomes 0.
REQ-025 SHALL, when restart is asserted, set state <= A and clear out_val.
REQ-026 SHALL accept no transfer in a restart cycle; hit_count is unaffected by restart.
REQ-027 SHALL make out_msg a don't-care while out_val = 0.

Reset
REQ-028 SHALL, while reset is asserted, immediately force state = A, out_val = 0, out_msg = 0 and hit_count = 0, regardless of clk.
REQ-029 SHALL, when reset asserts mid-operation, discard any pending output entry.
REQ-030 SHALL allow the first transfer on the first rising edge after reset deasserts.

Configuration
REQ-031 SHALL, with FSM_STREAM_CTRL_HITCNT_EN defined, implement hit_clr and hit_count per REQ-022 to REQ-024.
REQ-032 SHALL, without FSM_STREAM_CTRL_HITCNT_EN, tie hit_count to 0, ignore hit_clr and instantiate no counter flops.

Structure
REQ-033 SHALL place the state typedef (A/B/C/D, 2 bits) and the out_msg field widths in the shared package fsm_stream_pkg.
REQ-034 SHALL implement the combinational table of REQ-013 and REQ-014 in the sub-module fsm_4s2i1o_next_logic, with inputs state and in_ and outputs state_next and out.
REQ-035 SHALL keep the state, output-buffer and counter registers in fsm_stream_ctrl.

Verification
REQ-036 SHALL cover reset: with reset high and no clk edge -> state=0, out_val=0, hit_count=0.
REQ-037 SHALL cover a basic sequence: from A, with out_rdy=1, feed 01, 00, 01 -> out_msg = 3'b010, 3'b100, 3'b111 on consecutive cycles; state=D; hit_count=1.
REQ-038 SHALL cover back-pressure: out_rdy=0 with in_val=1 for 4 cycles -> exactly one transfer, in_rdy=0 afterwards, state and out_msg held; raising out_rdy pops the entry and accepts the next symbol on the same edge.
REQ-039 SHALL cover restart: in state C, restart=1 with in_val=1 and in_msg=01 -> state=A, out_val=0, no transfer, hit_count unchanged.
REQ-040 SHALL cover saturation and clear: with HIT_W=8, 300 transfers of 11 -> hit_count=255; hit_clr together with a transfer of 11 -> hit_count=0.
REQ-041 SHALL cover the configuration: built without FSM_STREAM_CTRL_HITCNT_EN, the same stimulus as REQ-040 -> hit_count=0 throughout.
